unidad_condicional: RTL and testbench
=====================================

// Module: unidad_condicional
// PURPOSE
//  Execute-stage stage that sits directly downstream of unidad_logico_aritmetica.
//  Holds the architectural NZCV flag register and evaluates the ARM condition field against it.
//  Gates the instruction's register, memory and PC writes, and registers result plus controls
//  into the writeback pipeline register. Also keeps a saturating count of squashed instructions.
// PARAMETERS
//  N      32  data width of resultado_in/resultado_out; matches the ALU width parameter
//  CNT_W  8   width of the squashed-instruction counter
// PORTS
//  clk            in   1      single clock; all state updates on posedge clk
//  rst            in   1      synchronous reset, active-high
//  valid_in       in   1      instruction present in execute stage this cycle
//  resultado_in   in   N      ALU result
//  flagNegativo   in   1      ALU N flag
//  flagCero       in   1      ALU Z flag
//  flagOverflow   in   1      ALU V flag
//  flagCarry      in   1      ALU C flag
//  cond           in   4      ARM condition field of the instruction
//  set_flags      in   1      S bit: instruction updates NZCV
//  reg_write      in   1      instruction writes the register file
//  mem_write      in   1      instruction writes memory
//  pc_src         in   1      instruction writes the PC (branch)
//  stall          in   1      hold this stage
//  flush          in   1      squash the instruction in this stage
//  cond_ex        out  1      combinational: cond passes against the current flag register
//  valid_out      out  1      registered valid toward writeback
//  resultado_out  out  N      registered result
//  reg_write_out  out  1      registered gated reg_write
//  mem_write_out  out  1      registered gated mem_write
//  pc_src_out     out  1      registered gated pc_src
//  flags_q        out  4      flag register, packed {N,Z,C,V}
//  anuladas       out  CNT_W  saturating count of valid instructions failing cond
// BEHAVIOUR
//  - Reset, on any cycle including mid-stall:
//    - valid_out, resultado_out, all *_out, flags_q and anuladas all go to 0
//  - cond_ex uses flags_q (pre-update flags), never the incoming ALU flags:
//    - 0000 EQ Z; 0001 NE !Z; 0010 CS C; 0011 CC !C
//    - 0100 MI N; 0101 PL !N; 0110 VS V; 0111 VC !V
//    - 1000 HI C&!Z; 1001 LS !C|Z; 1010 GE N==V; 1011 LT N!=V
//    - 1100 GT !Z&(N==V); 1101 LE Z|(N!=V); 1110 AL 1; 1111 0 (never)
//  - adv = valid_in & !stall & !flush; pass = adv & cond_ex.
//  - Latency 1 cycle: when !stall, output registers load on the next posedge:
//    - valid_out    <= valid_in & !flush
//    - resultado_out <= resultado_in
//    - reg_write_out <= reg_write & pass; mem_write_out <= mem_write & pass
//    - pc_src_out    <= pc_src & pass
//  - flags_q <= {flagNegativo,flagCero,flagCarry,flagOverflow} only when pass & set_flags;
//    otherwise flags_q holds.
//  - anuladas increments when adv & !cond_ex, saturating at all-ones (no wrap).
//  - stall & !flush: every register holds, outputs are stable, flags are not updated.
//  - flush (wins over stall): valid_out and all gated writes go to 0 next cycle;
//    flags_q and anuladas hold.
//  - valid_in=0: gated writes go to 0, flags hold, counter holds.
// TESTING
//  - Reset: assert rst 2 cycles -> all outputs 0, flags_q=4'b0000, anuladas=0.
//  - Flags, N=4: resultado_in=4'b0000, Z=1, set_flags=1, cond=1110 -> next cycle flags_q=4'b0100.
//    Then cond=0000, reg_write=1 -> cond_ex=1, reg_write_out=1.
//  - NE squash: flags_q Z=1, cond=0001, reg_write=1, mem_write=1, set_flags=1, N=1 ->
//    reg_write_out=0, mem_write_out=0, flags_q unchanged, anuladas=1.
//  - Signed compare: flags_q N=1,V=0 -> cond 1011 (LT) cond_ex=1; cond 1010 (GE) cond_ex=0;
//    cond 1111 always gives cond_ex=0.
//  - Stall/flush: stall 3 cycles with new inputs -> outputs and flags frozen.
//    stall=1 and flush=1 together -> valid_out=0 next cycle.
//  - Saturation: 300 consecutive failing valid instructions -> anuladas stops at 8'hFF.

Source files
------------

// File: rtl/unidad_condicional.sv
// Execute-stage conditional unit: holds NZCV, evaluates the ARM condition field against it,
// gates register/memory/PC writes and registers the result into the writeback pipeline register.
module unidad_condicional #(
    parameter int unsigned N     = 32,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             valid_in,
    input  logic [N-1:0]     resultado_in,
    input  logic             flagNegativo,
    input  logic             flagCero,
    input  logic             flagOverflow,
    input  logic             flagCarry,
    input  logic [3:0]       cond,
    input  logic             set_flags,
    input  logic             reg_write,
    input  logic             mem_write,
    input  logic             pc_src,
    input  logic             stall,
    input  logic             flush,
    output logic             cond_ex,
    output logic             valid_out,
    output logic [N-1:0]     resultado_out,
    output logic             reg_write_out,
    output logic             mem_write_out,
    output logic             pc_src_out,
    output logic [3:0]       flags_q,
    output logic [CNT_W-1:0] anuladas
);

    localparam int unsigned FLAG_W = 4;
    localparam int unsigned BIT_N  = 3;
    localparam int unsigned BIT_Z  = 2;
    localparam int unsigned BIT_C  = 1;
    localparam int unsigned BIT_V  = 0;

    logic             f_n, f_z, f_c, f_v;
    logic             adv, pass, load;
    logic             valid_q, valid_d;
    logic [N-1:0]     resultado_q, resultado_d;
    logic             reg_write_q, reg_write_d;
    logic             mem_write_q, mem_write_d;
    logic             pc_src_q, pc_src_d;
    logic [FLAG_W-1:0] flags_d;
    logic [CNT_W-1:0] anuladas_q, anuladas_d;

    assign f_n = flags_q[BIT_N];
    assign f_z = flags_q[BIT_Z];
    assign f_c = flags_q[BIT_C];
    assign f_v = flags_q[BIT_V];

    // Condition evaluation always uses the committed flags, never the incoming ALU flags
    always_comb begin
        cond_ex = 1'b0;
        unique case (cond)
            4'b0000: cond_ex = f_z;
            4'b0001: cond_ex = !f_z;
            4'b0010: cond_ex = f_c;
            4'b0011: cond_ex = !f_c;
            4'b0100: cond_ex = f_n;
            4'b0101: cond_ex = !f_n;
            4'b0110: cond_ex = f_v;
            4'b0111: cond_ex = !f_v;
            4'b1000: cond_ex = f_c && !f_z;
            4'b1001: cond_ex = !f_c || f_z;
            4'b1010: cond_ex = (f_n == f_v);
            4'b1011: cond_ex = (f_n != f_v);
            4'b1100: cond_ex = !f_z && (f_n == f_v);
            4'b1101: cond_ex = f_z || (f_n != f_v);
            4'b1110: cond_ex = 1'b1;
            default: cond_ex = 1'b0;
        endcase
    end

    assign adv  = valid_in && !stall && !flush;
    assign pass = adv && cond_ex;
    // Flush overrides stall so the squashed slot drains instead of holding
    assign load = !stall || flush;

    always_comb begin
        valid_d     = valid_q;
        resultado_d = resultado_q;
        reg_write_d = reg_write_q;
        mem_write_d = mem_write_q;
        pc_src_d    = pc_src_q;
        flags_d     = flags_q;
        anuladas_d  = anuladas_q;

        if (load) begin
            valid_d     = valid_in && !flush;
            resultado_d = resultado_in;
            reg_write_d = reg_write && pass;
            mem_write_d = mem_write && pass;
            pc_src_d    = pc_src && pass;
        end

        if (pass && set_flags) begin
            flags_d = {flagNegativo, flagCero, flagCarry, flagOverflow};
        end

        // Saturating squash counter: stops at all-ones
        if (adv && !cond_ex && (anuladas_q != {CNT_W{1'b1}})) begin
            anuladas_d = anuladas_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q     <= 1'b0;
            resultado_q <= '0;
            reg_write_q <= 1'b0;
            mem_write_q <= 1'b0;
            pc_src_q    <= 1'b0;
            flags_q     <= '0;
            anuladas_q  <= '0;
        end else begin
            valid_q     <= valid_d;
            resultado_q <= resultado_d;
            reg_write_q <= reg_write_d;
            mem_write_q <= mem_write_d;
            pc_src_q    <= pc_src_d;
            flags_q     <= flags_d;
            anuladas_q  <= anuladas_d;
        end
    end

    assign valid_out     = valid_q;
    assign resultado_out = resultado_q;
    assign reg_write_out = reg_write_q;
    assign mem_write_out = mem_write_q;
    assign pc_src_out    = pc_src_q;
    assign anuladas      = anuladas_q;

endmodule

// File: tb/tb_unidad_condicional.sv
// Directed-vector bench for unidad_condicional: driver pushes hand-computed expectations,
// a separate monitor pops and compares the registered outputs one cycle later.
module tb_unidad_condicional;

    localparam int unsigned N     = 32;
    localparam int unsigned CNT_W = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             valid_in;
    logic [N-1:0]     resultado_in;
    logic             flagNegativo, flagCero, flagOverflow, flagCarry;
    logic [3:0]       cond;
    logic             set_flags, reg_write, mem_write, pc_src, stall, flush;
    logic             cond_ex, valid_out, reg_write_out, mem_write_out, pc_src_out;
    logic [N-1:0]     resultado_out;
    logic [3:0]       flags_q;
    logic [CNT_W-1:0] anuladas;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        rst, valid;
        logic [31:0] res;
        logic [3:0]  fin;   // {N,Z,C,V}
        logic [3:0]  cnd;
        logic        sf, rw, mw, pc, st, fl;
        logic        e_ce, e_v;
        logic [31:0] e_res;
        logic        c_res;
        logic        e_rw, e_mw, e_pc;
        logic [3:0]  e_fl;
        logic [7:0]  e_an;
    } vec_t;

    vec_t vecs[$];
    vec_t exp_q[$];

    unidad_condicional #(.N(N), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .valid_in(valid_in), .resultado_in(resultado_in),
        .flagNegativo(flagNegativo), .flagCero(flagCero), .flagOverflow(flagOverflow),
        .flagCarry(flagCarry), .cond(cond), .set_flags(set_flags), .reg_write(reg_write),
        .mem_write(mem_write), .pc_src(pc_src), .stall(stall), .flush(flush),
        .cond_ex(cond_ex), .valid_out(valid_out), .resultado_out(resultado_out),
        .reg_write_out(reg_write_out), .mem_write_out(mem_write_out),
        .pc_src_out(pc_src_out), .flags_q(flags_q), .anuladas(anuladas)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(
        input logic r, input logic v, input logic [31:0] res, input logic [3:0] fin,
        input logic [3:0] c, input logic sf, input logic rw, input logic mw, input logic pc,
        input logic st, input logic fl, input logic ece, input logic ev, input logic [31:0] eres,
        input logic cres, input logic erw, input logic emw, input logic epc,
        input logic [3:0] efl, input logic [7:0] ean);
        vec_t t;
        t.rst = r; t.valid = v; t.res = res; t.fin = fin; t.cnd = c;
        t.sf = sf; t.rw = rw; t.mw = mw; t.pc = pc; t.st = st; t.fl = fl;
        t.e_ce = ece; t.e_v = ev; t.e_res = eres; t.c_res = cres;
        t.e_rw = erw; t.e_mw = emw; t.e_pc = epc; t.e_fl = efl; t.e_an = ean;
        return t;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: compare registered outputs after each edge against the queued expectation
    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) begin
            vec_t e;
            e = exp_q.pop_front();
            chk("valid_out", 64'(valid_out), 64'(e.e_v));
            if (e.c_res) chk("resultado_out", 64'(resultado_out), 64'(e.e_res));
            chk("reg_write_out", 64'(reg_write_out), 64'(e.e_rw));
            chk("mem_write_out", 64'(mem_write_out), 64'(e.e_mw));
            chk("pc_src_out", 64'(pc_src_out), 64'(e.e_pc));
            chk("flags_q", 64'(flags_q), 64'(e.e_fl));
            chk("anuladas", 64'(anuladas), 64'(e.e_an));
        end
    end

    initial begin
        int unsigned an;
        rst = 1'b1; valid_in = 1'b0; resultado_in = '0;
        flagNegativo = 1'b0; flagCero = 1'b0; flagOverflow = 1'b0; flagCarry = 1'b0;
        cond = 4'hF; set_flags = 1'b0; reg_write = 1'b0; mem_write = 1'b0;
        pc_src = 1'b0; stall = 1'b0; flush = 1'b0;

        // rst valid res fin cond sf rw mw pc st fl | ce v res cres rw mw pc flags an
        vecs.push_back(mk(1,0,32'h0,4'h0,4'hF,0,0,0,0,0,0, 0, 0,32'h0,1,0,0,0,4'h0,8'd0));
        vecs.push_back(mk(1,0,32'h0,4'h0,4'hF,0,0,0,0,0,0, 0, 0,32'h0,1,0,0,0,4'h0,8'd0));
        vecs.push_back(mk(0,1,32'h0,4'b0100,4'hE,1,0,0,0,0,0, 1, 1,32'h0,1,0,0,0,4'b0100,8'd0));
        vecs.push_back(mk(0,1,32'h55,4'h0,4'h0,0,1,0,0,0,0, 1, 1,32'h55,1,1,0,0,4'b0100,8'd0));
        vecs.push_back(mk(0,1,32'h11,4'b1000,4'h1,1,1,1,0,0,0, 0, 1,32'h11,1,0,0,0,4'b0100,8'd1));
        vecs.push_back(mk(0,1,32'h80000000,4'b1000,4'hE,1,0,0,1,0,0, 1, 1,32'h80000000,1,0,0,1,4'b1000,8'd1));
        vecs.push_back(mk(0,1,32'h6,4'h0,4'hB,0,1,0,0,0,0, 1, 1,32'h6,1,1,0,0,4'b1000,8'd1));
        vecs.push_back(mk(0,1,32'h7,4'h0,4'hA,0,1,1,0,0,0, 0, 1,32'h7,1,0,0,0,4'b1000,8'd2));
        vecs.push_back(mk(0,1,32'h8,4'h0,4'hF,0,0,0,1,0,0, 0, 1,32'h8,1,0,0,0,4'b1000,8'd3));
        vecs.push_back(mk(0,1,32'h9,4'h0,4'h4,0,0,1,0,0,0, 1, 1,32'h9,1,0,1,0,4'b1000,8'd3));
        vecs.push_back(mk(0,1,32'hA,4'h0,4'hC,0,1,0,0,0,0, 0, 1,32'hA,1,0,0,0,4'b1000,8'd4));
        vecs.push_back(mk(0,1,32'hB,4'h0,4'hD,0,1,0,0,0,0, 1, 1,32'hB,1,1,0,0,4'b1000,8'd4));
        // three stalled cycles with fresh inputs: everything frozen
        vecs.push_back(mk(0,1,32'hDEAD,4'b0010,4'hE,1,1,0,0,1,0, 1, 1,32'hB,1,1,0,0,4'b1000,8'd4));
        vecs.push_back(mk(0,1,32'hBEEF,4'h0,4'hF,0,1,1,0,1,0, 0, 1,32'hB,1,1,0,0,4'b1000,8'd4));
        vecs.push_back(mk(0,0,32'hCAFE,4'b0001,4'hE,1,0,1,1,1,0, 1, 1,32'hB,1,1,0,0,4'b1000,8'd4));
        // stall together with flush
        vecs.push_back(mk(0,1,32'hF,4'b0010,4'hE,1,1,0,0,1,1, 1, 0,32'h0,0,0,0,0,4'b1000,8'd4));
        vecs.push_back(mk(0,1,32'h10,4'h0,4'hF,0,1,0,0,0,1, 0, 0,32'h10,1,0,0,0,4'b1000,8'd4));
        vecs.push_back(mk(0,0,32'h11,4'b0100,4'hE,1,1,1,0,0,0, 1, 0,32'h11,1,0,0,0,4'b1000,8'd4));
        vecs.push_back(mk(0,1,32'h12,4'h0,4'h8,0,1,0,0,0,0, 0, 1,32'h12,1,0,0,0,4'b1000,8'd5));
        vecs.push_back(mk(0,1,32'h13,4'b0010,4'hE,1,0,0,0,0,0, 1, 1,32'h13,1,0,0,0,4'b0010,8'd5));
        vecs.push_back(mk(0,1,32'h14,4'h0,4'h8,0,1,0,0,0,0, 1, 1,32'h14,1,1,0,0,4'b0010,8'd5));
        vecs.push_back(mk(0,1,32'h15,4'h0,4'h2,0,0,1,0,0,0, 1, 1,32'h15,1,0,1,0,4'b0010,8'd5));
        vecs.push_back(mk(0,1,32'h16,4'h0,4'h3,0,1,0,0,0,0, 0, 1,32'h16,1,0,0,0,4'b0010,8'd6));
        vecs.push_back(mk(0,1,32'h17,4'h0,4'h7,0,0,0,1,0,0, 1, 1,32'h17,1,0,0,1,4'b0010,8'd6));
        vecs.push_back(mk(0,1,32'h18,4'h0,4'h9,0,1,0,0,0,0, 0, 1,32'h18,1,0,0,0,4'b0010,8'd7));
        // reset while stalled
        vecs.push_back(mk(1,1,32'h19,4'hF,4'hF,1,1,1,1,1,0, 0, 0,32'h0,1,0,0,0,4'h0,8'd0));
        // saturation run of never-executing instructions
        for (int i = 0; i < 300; i++) begin
            an = (i + 1 >= 255) ? 255 : i + 1;
            vecs.push_back(mk(0,1,32'(i),4'h0,4'hF,0,1,0,0,0,0, 0, 1,32'(i),1,0,0,0,4'h0,8'(an)));
        end
        vecs.push_back(mk(1,0,32'h0,4'h0,4'hF,0,0,0,0,0,0, 0, 0,32'h0,1,0,0,0,4'h0,8'd0));

        foreach (vecs[k]) begin
            @(negedge clk);
            rst = vecs[k].rst; valid_in = vecs[k].valid; resultado_in = vecs[k].res;
            {flagNegativo, flagCero, flagCarry, flagOverflow} = vecs[k].fin;
            cond = vecs[k].cnd; set_flags = vecs[k].sf; reg_write = vecs[k].rw;
            mem_write = vecs[k].mw; pc_src = vecs[k].pc; stall = vecs[k].st; flush = vecs[k].fl;
            #1;
            chk("cond_ex", 64'(cond_ex), 64'(vecs[k].e_ce));
            exp_q.push_back(vecs[k]);
        end

        for (int w = 0; w < 10 && exp_q.size() > 0; w++) @(negedge clk);
        if (exp_q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
